// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: sequencing controller in front of a 16-bit adder with a
// ready-based handshake.
//
// Accepts one operand request, registers the operands onto the adder and
// holds add_en high until the adder reports ready. It then captures the sum
// and carry and presents them downstream until res_ready is seen. The
// controller does no arithmetic: captured values pass through bit-exact.
//
// Optional feature, compile-time macro ADD_SEQ_TIMEOUT_EN:
//   when defined, an 8-bit wait counter aborts a transaction after
//   TIMEOUT_CYCLES cycles in WAIT without ready. The result is then zero and
//   res_err is set.
//   When undefined, no counter is built, res_err is tied to 0 and WAIT lasts
//   until ready.

module add_seq_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,

    // Upstream request
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    input  logic        req_cin,

    // Adder side
    output logic        add_en,
    output logic [15:0] A,
    output logic [15:0] B,
    output logic        c_in,
    input  logic        ready,
    input  logic [15:0] Output,
    input  logic        c_out,

    // Downstream result
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_sum,
    output logic        res_cout,
    output logic        res_err
);

    // Reject out-of-range timeouts at elaboration; the counter is only 8 bits.
    if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
        $error("add_seq_ctrl: TIMEOUT_CYCLES must lie in 2..255");
    end

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [15:0] a_q;
    logic [15:0] b_q;
    logic        cin_q;
    logic [15:0] sum_q;
    logic        cout_q;

    // The adder's ready only counts once the operands have been on the
    // adder for the ISSUE cycle; a ready seen in ISSUE may be stale.
    logic ready_hit;
    logic tmo_hit;

    assign ready_hit = (state_q == StWait) && ready;

`ifdef ADD_SEQ_TIMEOUT_EN
    localparam logic [7:0] TmoLast = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] tmo_cnt_q;
    logic       err_q;

    // Ready wins over a timeout landing in the same cycle.
    assign tmo_hit = (state_q == StWait) && !ready && (tmo_cnt_q == TmoLast);

    // Wait counter: cleared while issuing, counts completed WAIT cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= 8'd0;
        end else if (state_q == StIssue) begin
            tmo_cnt_q <= 8'd0;
        end else if (state_q == StWait) begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
        end
    end

    // Error flag: set by a timeout, cleared by a real result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (ready_hit) begin
            err_q <= 1'b0;
        end else if (tmo_hit) begin
            err_q <= 1'b1;
        end
    end

    assign res_err = err_q;
`else
    assign tmo_hit = 1'b0;
    assign res_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. DONE always returns through IDLE, so a request can
    // never be taken in the cycle a result is released.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                state_d = StWait;
            end
            StWait: begin
                if (ready_hit || tmo_hit) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (res_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decoded from the current state only, so reset clears them at once.
    always_comb begin
        req_ready = 1'b0;
        add_en    = 1'b0;
        res_valid = 1'b0;
        unique case (state_q)
            StIdle:  req_ready = 1'b1;
            StIssue: add_en    = 1'b1;
            StWait:  add_en    = 1'b1;
            StDone:  res_valid = 1'b1;
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

    // Operand registers: loaded on acceptance, frozen for the rest of the
    // transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= 16'd0;
            b_q   <= 16'd0;
            cin_q <= 1'b0;
        end else if ((state_q == StIdle) && req_valid) begin
            a_q   <= req_a;
            b_q   <= req_b;
            cin_q <= req_cin;
        end
    end

    // Result registers: capture the adder output on ready, zero on timeout,
    // otherwise hold so DONE presents a stable result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q  <= 16'd0;
            cout_q <= 1'b0;
        end else if (ready_hit) begin
            sum_q  <= Output;
            cout_q <= c_out;
        end else if (tmo_hit) begin
            sum_q  <= 16'd0;
            cout_q <= 1'b0;
        end
    end

    assign A        = a_q;
    assign B        = b_q;
    assign c_in     = cin_q;
    assign res_sum  = sum_q;
    assign res_cout = cout_q;

endmodule

// File: doc/add_seq_ctrl.md
ADD_SEQ_CTRL -- requirements
Module: add_seq_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 32: maximum wait for adder ready, in cycles (range 2..255).
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  1  upstream operand request present.
REQ-005 req_ready  output  1  controller accepts a request this cycle.
REQ-006 req_a, req_b  input  16 each  operands.
REQ-007 req_cin  input  1  carry-in.
REQ-008 add_en  output  1  enable to the 16-bit adder.
REQ-009 A, B  output  16 each  registered operands to the adder.
REQ-010 c_in  output  1  registered carry-in to the adder.
REQ-011 ready  input  1  adder result valid.
REQ-012 Output  input  16  adder sum.
REQ-013 c_out  input  1  adder carry-out.
REQ-014 res_valid  output  1  result held for downstream.
REQ-015 res_ready  input  1  downstream accepts the result.
REQ-016 res_sum  output  16  captured sum; res_cout  output  1  captured carry; res_err  output  1  timeout flag.

Function
REQ-017 The FSM SHALL have four states: IDLE, ISSUE, WAIT and DONE.
REQ-018 IDLE: req_ready=1; on req_valid the block latches req_a, req_b and req_cin into A, B and c_in, then goes to ISSUE.
REQ-019 req_ready SHALL be 1 only in IDLE, and at most one request SHALL be accepted per transaction.
REQ-020 ISSUE: add_en=1; ready is ignored for this one cycle (it may be stale); the state then goes to WAIT.
REQ-021 WAIT: add_en=1; A, B and c_in SHALL stay stable.
REQ-022 WAIT, on a sampled ready=1: capture Output into res_sum and c_out into res_cout, clear res_err, drop add_en on the next cycle, go to DONE.
REQ-023 DONE: res_valid=1 and add_en=0; res_sum, res_cout and res_err SHALL stay stable until res_ready=1, after which the state returns to IDLE.
REQ-024 A request SHALL NOT be accepted in the same cycle as DONE exits; minimum throughput is one result per 4 cycles.
REQ-025 Latency from req_valid&req_ready to res_valid SHALL be 2 cycles plus the adder's ready latency.
REQ-026 add_en SHALL be low for at least 1 cycle between transactions, so the adder re-arms.
REQ-027 res_valid=1 with res_ready=1 held permanently SHALL still pass through IDLE for one cycle each transaction.
REQ-028 No arithmetic is performed in this block; the captured values pass through bit-exact.

Reset
REQ-029 rst=1 SHALL force, immediately and without waiting for a clock edge: state=IDLE, add_en=0, A=B=0, c_in=0, res_valid=0, res_sum=0, res_cout=0, res_err=0, and the timeout counter to 0.
REQ-030 A transaction in progress at reset SHALL be discarded without producing a result.
REQ-031 After rst deasserts, req_ready=1 from the first clock onward.

Configuration
REQ-032 Macro ADD_SEQ_TIMEOUT_EN:
- When defined, an 8-bit counter SHALL clear in ISSUE and increment each cycle in WAIT.
- If the counter reaches TIMEOUT_CYCLES without ready, the block SHALL go to DONE with res_err=1, res_sum=0 and res_cout=0, and drop add_en.
REQ-033 When ADD_SEQ_TIMEOUT_EN is undefined, no counter SHALL exist, res_err SHALL be constant 0, and WAIT SHALL last indefinitely.

Verification
REQ-034 A=127, B=127, cin=0, adder ready after 3 cycles -> res_sum=254, res_cout=0, res_err=0, res_valid 5 cycles after acceptance.
REQ-035 0xFFFF+0x0001, cin=0 -> res_sum=0x0000, res_cout=1; 0xFFFF+0xFFFF, cin=1 -> res_sum=0xFFFF, res_cout=1.
REQ-036 res_ready held 0 for 10 cycles -> res_valid, res_sum and res_cout unchanged, req_ready=0 throughout, add_en=0.
REQ-037 Stale ready=1 in the ISSUE cycle -> not captured; the capture uses the ready sampled in WAIT.
REQ-038 With ADD_SEQ_TIMEOUT_EN defined, TIMEOUT_CYCLES=8 and ready never asserted -> res_valid=1, res_err=1 after 8 WAIT cycles; without the macro -> res_valid stays 0 for 100 cycles.
REQ-039 rst pulsed in WAIT -> add_en=0 and res_valid=0 within the same cycle; the next request 0x0003+0x0004 -> res_sum=0x0007.
